// File: rtl/controle_de_sequencia_pkg.sv
// rtl/controle_de_sequencia_pkg.sv - state encoding and default sizes; LIMITE_TENTATIVAS_EN adds BLOQUEADO
package controle_de_sequencia_pkg;

    localparam int MAX_CODIGOS = 8;
    localparam int LARGURA     = 7;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        PROGRAMANDO = 3'd1,
        VERIFICANDO = 3'd2,
        ACERTO      = 3'd3,
        ERRO        = 3'd4
`ifdef LIMITE_TENTATIVAS_EN
        , BLOQUEADO = 3'd5
`endif
    } estado_t;

endpackage

// File: rtl/controle_de_sequencia_if.sv
// rtl/controle_de_sequencia_if.sv - user-side control/code bus of the sequence checker
interface controle_de_sequencia_if #(
    parameter int MAX_CODIGOS = controle_de_sequencia_pkg::MAX_CODIGOS,
    parameter int LARGURA     = controle_de_sequencia_pkg::LARGURA
);
    localparam int IW = $clog2(MAX_CODIGOS);

    logic               programar;
    logic               verificar;
    logic               concluir;
    logic               entrada_valida;
    logic [LARGURA-1:0] codigo;
    logic               ocupado;
    logic               acerto;
    logic               erro;
    logic [IW-1:0]      indice;
    logic [IW:0]        tamanho;
    logic               bloqueado;

    modport master (
        output programar, verificar, concluir, entrada_valida, codigo,
        input  ocupado, acerto, erro, indice, tamanho, bloqueado
    );

    modport slave (
        input  programar, verificar, concluir, entrada_valida, codigo,
        output ocupado, acerto, erro, indice, tamanho, bloqueado
    );

endinterface

// File: rtl/comparador_de_igualdade.sv
// rtl/comparador_de_igualdade.sv - combinational equality compare of two codes
module comparador_de_igualdade #(
    parameter int LARGURA = 7
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               igual
);

    assign igual = (a == b);

endmodule

// File: rtl/controle_de_sequencia.sv
// rtl/controle_de_sequencia.sv - code-sequence programming and checking FSM; LIMITE_TENTATIVAS_EN enables lockout
module controle_de_sequencia
    import controle_de_sequencia_pkg::*;
#(
    parameter int MAX_CODIGOS = controle_de_sequencia_pkg::MAX_CODIGOS,
    parameter int LARGURA     = controle_de_sequencia_pkg::LARGURA
) (
    input  logic                   clock,
    input  logic                   reset,
    controle_de_sequencia_if.slave bus
);

    localparam int            IW    = $clog2(MAX_CODIGOS);
    localparam logic [IW:0]   CHEIO = (IW+1)'(MAX_CODIGOS);
    localparam logic [IW:0]   UM_T  = (IW+1)'(1);
    localparam logic [IW-1:0] UM_I  = IW'(1);

    estado_t            estado;
    estado_t            estado_prox;
    logic [LARGURA-1:0] mem [MAX_CODIGOS];
    logic [IW:0]        tamanho_q;
    logic [IW-1:0]      indice_q;
    logic               igual;
    logic               ultimo_prog;
    logic               ultimo_ver;
    logic               ocupado_c;
    logic               acerto_c;
    logic               erro_c;
    logic               bloqueado_c;

    comparador_de_igualdade #(.LARGURA(LARGURA)) u_comparador (
        .a     (bus.codigo),
        .b     (mem[indice_q]),
        .igual (igual)
    );

    assign ultimo_prog = (tamanho_q + UM_T) == CHEIO;
    assign ultimo_ver  = ({1'b0, indice_q} + UM_T) == tamanho_q;

`ifdef LIMITE_TENTATIVAS_EN
    logic [1:0] falhas_q;

    always_ff @(posedge clock) begin
        if (reset)                 falhas_q <= '0;
        else if (estado == ERRO)   falhas_q <= falhas_q + 2'd1;
        else if (estado == ACERTO) falhas_q <= '0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (bus.programar)      estado_prox = PROGRAMANDO;
                else if (bus.verificar) estado_prox = (tamanho_q == '0) ? ERRO : VERIFICANDO;
            end
            PROGRAMANDO: begin
                if (bus.concluir || (bus.entrada_valida && ultimo_prog)) estado_prox = OCIOSO;
            end
            VERIFICANDO: begin
                if (bus.concluir)            estado_prox = OCIOSO;
                else if (bus.entrada_valida) estado_prox = !igual ? ERRO : (ultimo_ver ? ACERTO : VERIFICANDO);
            end
            ACERTO: estado_prox = OCIOSO;
`ifdef LIMITE_TENTATIVAS_EN
            // falhas_q still holds the count before this erro, so 2 means third in a row
            ERRO:      estado_prox = (falhas_q == 2'd2) ? BLOQUEADO : OCIOSO;
            BLOQUEADO: estado_prox = BLOQUEADO;
`else
            ERRO:      estado_prox = OCIOSO;
`endif
            default:   estado_prox = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado_c   = (estado != OCIOSO);
        acerto_c    = (estado == ACERTO);
        erro_c      = (estado == ERRO);
        bloqueado_c = 1'b0;
`ifdef LIMITE_TENTATIVAS_EN
        bloqueado_c = (estado == BLOQUEADO);
`endif
    end

    always_ff @(posedge clock) begin
        if ((estado == PROGRAMANDO) && bus.entrada_valida) mem[tamanho_q[IW-1:0]] <= bus.codigo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tamanho_q <= '0;
            indice_q  <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.programar)      tamanho_q <= '0;
                    else if (bus.verificar) indice_q  <= '0;
                end
                PROGRAMANDO: begin
                    if (bus.entrada_valida) tamanho_q <= tamanho_q + UM_T;
                end
                VERIFICANDO: begin
                    if (bus.concluir)                         indice_q <= '0;
                    else if (bus.entrada_valida && igual && !ultimo_ver) indice_q <= indice_q + UM_I;
                    else if (bus.entrada_valida)              indice_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ocupado   = ocupado_c;
    assign bus.acerto    = acerto_c;
    assign bus.erro      = erro_c;
    assign bus.bloqueado = bloqueado_c;
    assign bus.indice    = indice_q;
    assign bus.tamanho   = tamanho_q;

endmodule

// File: tb/tb_controle_de_sequencia.sv
// tb/tb_controle_de_sequencia.sv - directed bench with pulse scoreboard; LIMITE_TENTATIVAS_EN selects lockout expectations
module tb_controle_de_sequencia;

    typedef struct {
        bit acerto;
        int ciclo;
    } esperado_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    int        cyc = 0;
    int        checks = 0;
    int        failures = 0;
    esperado_t exp_q[$];

    controle_de_sequencia_if #(.MAX_CODIGOS(8), .LARGURA(7)) bus ();

    controle_de_sequencia #(.MAX_CODIGOS(8), .LARGURA(7)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // every acerto/erro cycle must match the oldest expected pulse in kind and cycle
    always @(negedge clk) begin
        esperado_t e;
        if (bus.acerto || bus.erro) begin
            chk("pulso_exclusivo", 32'(bus.acerto & bus.erro), 32'd0);
            if (exp_q.size() == 0) begin
                chk("pulso_inesperado", 32'(bus.acerto | bus.erro), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulso_tipo", 32'(bus.acerto), 32'(e.acerto));
                chk("pulso_ciclo", 32'(cyc), 32'(e.ciclo));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic espera_pulso(input bit acerto);
        exp_q.push_back('{acerto, cyc + 1});
    endtask

    task automatic strobe(input logic [6:0] c);
        bus.entrada_valida = 1'b1;
        bus.codigo         = c;
        tick();
        bus.entrada_valida = 1'b0;
    endtask

    task automatic inicia_prog();
        bus.programar = 1'b1;
        tick();
        bus.programar = 1'b0;
    endtask

    task automatic inicia_verif();
        bus.verificar = 1'b1;
        tick();
        bus.verificar = 1'b0;
    endtask

    task automatic conclui();
        bus.concluir = 1'b1;
        tick();
        bus.concluir = 1'b0;
    endtask

    task automatic programa3();
        inicia_prog();
        strobe(7'h41);
        strobe(7'h63);
        strobe(7'h77);
        conclui();
    endtask

    task automatic verifica_vazia();
        espera_pulso(1'b0);
        inicia_verif();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.programar      = 1'b0;
        bus.verificar      = 1'b0;
        bus.concluir       = 1'b0;
        bus.entrada_valida = 1'b0;
        bus.codigo         = '0;
        repeat (2) tick();
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_acerto", 32'(bus.acerto), 32'd0);
        chk("rst_erro", 32'(bus.erro), 32'd0);
        chk("rst_indice", 32'(bus.indice), 32'd0);
        chk("rst_tamanho", 32'(bus.tamanho), 32'd0);
        chk("rst_bloqueado", 32'(bus.bloqueado), 32'd0);
        rst = 1'b0;
        tick();

        // check with nothing programmed
        espera_pulso(1'b0);
        inicia_verif();
        chk("vazio_ocupado", 32'(bus.ocupado), 32'd1);
        chk("vazio_tamanho", 32'(bus.tamanho), 32'd0);
        tick();
        chk("vazio_ocioso", 32'(bus.ocupado), 32'd0);
        chk("vazio_fila", 32'(exp_q.size()), 32'd0);

        // 3-code program and full match
        programa3();
        chk("prog3_tamanho", 32'(bus.tamanho), 32'd3);
        chk("prog3_ocioso", 32'(bus.ocupado), 32'd0);
        inicia_verif();
        strobe(7'h41);
        chk("ver_indice1", 32'(bus.indice), 32'd1);
        strobe(7'h63);
        chk("ver_indice2", 32'(bus.indice), 32'd2);
        espera_pulso(1'b1);
        strobe(7'h77);
        chk("acerto_tamanho", 32'(bus.tamanho), 32'd3);
        tick();
        chk("acerto_fila", 32'(exp_q.size()), 32'd0);
        chk("acerto_ocioso", 32'(bus.ocupado), 32'd0);

        // mismatch on the second code
        inicia_verif();
        strobe(7'h41);
        espera_pulso(1'b0);
        strobe(7'h00);
        chk("erro_indice", 32'(bus.indice), 32'd0);
        chk("erro_ocupado", 32'(bus.ocupado), 32'd1);
        tick();
        chk("erro_ocioso", 32'(bus.ocupado), 32'd0);
        chk("erro_fila", 32'(exp_q.size()), 32'd0);

        // concluir beats a matching strobe in the same cycle
        inicia_verif();
        strobe(7'h41);
        bus.concluir = 1'b1;
        bus.entrada_valida = 1'b1;
        bus.codigo = 7'h63;
        tick();
        bus.concluir = 1'b0;
        bus.entrada_valida = 1'b0;
        chk("cancela_ocioso", 32'(bus.ocupado), 32'd0);
        chk("cancela_indice", 32'(bus.indice), 32'd0);
        tick();
        chk("cancela_fila", 32'(exp_q.size()), 32'd0);

        // strobe while idle has no effect
        strobe(7'h55);
        chk("ocioso_tamanho", 32'(bus.tamanho), 32'd3);
        chk("ocioso_ocupado", 32'(bus.ocupado), 32'd0);

        // programar wins over verificar; concluir with a strobe still writes
        bus.programar = 1'b1;
        bus.verificar = 1'b1;
        tick();
        bus.programar = 1'b0;
        bus.verificar = 1'b0;
        chk("prio_tamanho", 32'(bus.tamanho), 32'd0);
        chk("prio_ocupado", 32'(bus.ocupado), 32'd1);
        strobe(7'h11);
        chk("prog_tamanho1", 32'(bus.tamanho), 32'd1);
        bus.concluir = 1'b1;
        bus.entrada_valida = 1'b1;
        bus.codigo = 7'h22;
        tick();
        bus.concluir = 1'b0;
        bus.entrada_valida = 1'b0;
        chk("conclui_tamanho", 32'(bus.tamanho), 32'd2);
        chk("conclui_ocioso", 32'(bus.ocupado), 32'd0);
        inicia_verif();
        strobe(7'h11);
        espera_pulso(1'b1);
        strobe(7'h22);
        tick();
        chk("dois_fila", 32'(exp_q.size()), 32'd0);

        // fill to capacity; ninth strobe ignored
        inicia_prog();
        for (int i = 1; i <= 8; i++) strobe(7'(i));
        chk("cheio_tamanho", 32'(bus.tamanho), 32'd8);
        chk("cheio_ocioso", 32'(bus.ocupado), 32'd0);
        strobe(7'd9);
        chk("cheio_ignora", 32'(bus.tamanho), 32'd8);
        inicia_verif();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) espera_pulso(1'b1);
            strobe(7'(i));
            if (i < 8) chk("cheio_indice", 32'(bus.indice), 32'(i));
        end
        tick();
        chk("cheio_fila", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a check
        programa3();
        inicia_verif();
        strobe(7'h41);
        strobe(7'h63);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_indice", 32'(bus.indice), 32'd0);
        chk("abort_tamanho", 32'(bus.tamanho), 32'd0);
        chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
        tick();
        chk("abort_fila", 32'(exp_q.size()), 32'd0);
        espera_pulso(1'b0);
        inicia_verif();
        tick();
        chk("abort_inacessivel", 32'(exp_q.size()), 32'd0);

        // three consecutive errors
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) verifica_vazia();
        chk("tentativas_fila", 32'(exp_q.size()), 32'd0);
`ifdef LIMITE_TENTATIVAS_EN
        chk("bloq_ativo", 32'(bus.bloqueado), 32'd1);
        bus.programar = 1'b1;
        bus.verificar = 1'b1;
        repeat (3) tick();
        bus.programar = 1'b0;
        bus.verificar = 1'b0;
        chk("bloq_mantido", 32'(bus.bloqueado), 32'd1);
        chk("bloq_ocupado", 32'(bus.ocupado), 32'd1);
        chk("bloq_tamanho", 32'(bus.tamanho), 32'd0);
`else
        chk("sem_bloq", 32'(bus.bloqueado), 32'd0);
        chk("sem_bloq_ocioso", 32'(bus.ocupado), 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("final_bloqueado", 32'(bus.bloqueado), 32'd0);
        chk("final_ocupado", 32'(bus.ocupado), 32'd0);
        tick();
        chk("final_fila", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_de_sequencia.md
CONTROLE_DE_SEQUENCIA -- requirements
Module: controle_de_sequencia

Interface
REQ-001 SHALL have parameter MAX_CODIGOS, default 8: depth of the stored code sequence (power of two, 2..16).
REQ-002 SHALL have parameter LARGURA, default 7: width of each code.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port programar  in  1  level; in OCIOSO, starts programming.
REQ-006 SHALL have port verificar  in  1  level; in OCIOSO, starts a check.
REQ-007 SHALL have port concluir  in  1  ends programming or cancels a check.
REQ-008 SHALL have port entrada_valida  in  1  one-cycle strobe qualifying codigo.
REQ-009 SHALL have port codigo  in  LARGURA  code entered by the user.
REQ-010 SHALL have port ocupado  out  1  high whenever state is not OCIOSO.
REQ-011 SHALL have port acerto  out  1  one-cycle pulse; full sequence matched.
REQ-012 SHALL have port erro  out  1  one-cycle pulse; mismatch or check with empty sequence.
REQ-013 SHALL have port indice  out  clog2(MAX_CODIGOS)  position of next code to check.
REQ-014 SHALL have port tamanho  out  clog2(MAX_CODIGOS)+1  number of stored codes.
REQ-015 SHALL have port bloqueado  out  1  lockout indicator.

Function
REQ-016 SHALL implement states OCIOSO, PROGRAMANDO, VERIFICANDO, ACERTO, ERRO (plus BLOQUEADO, see Configuration).
REQ-017 In OCIOSO: programar -> PROGRAMANDO with tamanho cleared to 0; else verificar with tamanho>0 -> VERIFICANDO with indice=0; programar wins if both are high.
REQ-018 In OCIOSO, verificar with tamanho=0 SHALL go to ERRO (erro pulse next cycle), then OCIOSO.
REQ-019 In PROGRAMANDO, entrada_valida SHALL write codigo to mem[tamanho] and increment tamanho.
REQ-020 On the write that makes tamanho=MAX_CODIGOS, PROGRAMANDO SHALL go to OCIOSO; any further strobe is ignored, with no wrap or overwrite.
REQ-021 concluir in PROGRAMANDO SHALL go to OCIOSO; when entrada_valida is high in the same cycle, the write completes first.
REQ-022 In VERIFICANDO, entrada_valida SHALL compare codigo with mem[indice] combinationally, and the result SHALL be registered at that edge.
REQ-023 On a match with indice<tamanho-1, indice SHALL increment and the state SHALL remain VERIFICANDO.
REQ-024 On a match with indice=tamanho-1, the state SHALL go to ACERTO, asserting acerto for exactly the next cycle, then OCIOSO.
REQ-025 On a mismatch, the state SHALL go to ERRO, asserting erro for exactly the next cycle, with indice cleared to 0, then OCIOSO.
REQ-026 Latency from the deciding strobe edge to the acerto/erro pulse SHALL be 1 cycle.
REQ-027 concluir in VERIFICANDO SHALL return to OCIOSO with indice=0 and no pulse; if entrada_valida is in the same cycle, concluir wins.
REQ-028 entrada_valida SHALL be ignored in OCIOSO, ACERTO and ERRO.
REQ-029 acerto and erro SHALL never be high in the same cycle.
REQ-030 indice and tamanho SHALL be registered outputs.

Reset
REQ-031 Reset SHALL force state OCIOSO, tamanho=0, indice=0, acerto=0, erro=0, bloqueado=0 and error counter=0, and SHALL take priority over every input.
REQ-032 Reset mid-programming or mid-check SHALL abort with no pulse; memory contents need not be cleared but are unreachable until reprogrammed.

Configuration
REQ-033 Macro LIMITE_TENTATIVAS_EN, when defined, SHALL add a 2-bit consecutive-error counter, incremented on each erro and cleared on acerto.
REQ-034 With LIMITE_TENTATIVAS_EN defined, the third consecutive erro SHALL go from ERRO to BLOQUEADO.
REQ-035 In BLOQUEADO, bloqueado=1 and ocupado=1, and all inputs are ignored; only reset exits the state.
REQ-036 Without LIMITE_TENTATIVAS_EN, BLOQUEADO and the counter SHALL be absent, and bloqueado SHALL be tied to 0.

Structure
REQ-037 A shared package SHALL hold the state encoding enum and default constants MAX_CODIGOS and LARGURA.
REQ-038 The block SHALL instantiate the existing comparador_de_igualdade as its single sub-module for the codigo vs mem[indice] compare.

Verification
REQ-039 Program 3 codes (0x41, 0x63, 0x77) then concluir, and check 0x41, 0x63, 0x77 -> tamanho=3; acerto=1 one cycle after the 3rd strobe; erro stays 0.
REQ-040 Same program, check 0x41 then 0x00 -> erro pulse one cycle after the 2nd strobe; indice=0; state OCIOSO.
REQ-041 Program 9 codes without concluir -> tamanho=8 and return to OCIOSO after the 8th; the 9th is ignored; checking codes 1..8 gives acerto.
REQ-042 verificar after reset with no program -> erro pulse; tamanho=0.
REQ-043 Reset asserted after the 2nd of 3 check strobes -> no pulses; indice=0; tamanho=0; ocupado=0 next cycle.
REQ-044 With LIMITE_TENTATIVAS_EN, three consecutive mismatching checks -> bloqueado=1 and stays high under programar/verificar until reset.
